psum_drain_unpack: RTL

//  Drains packed partial sums from the edge of the core_cell PE array after a tile completes.
//  - Drives the array's cell_out_en shift chain, one strobe per word.
//  - Captures each word arriving at the edge cell and unpacks it per mode:

---
 rtl/psum_pkg.sv | 23 ++
 rtl/psum_fifo.sv | 45 ++++
 rtl/psum_drain_unpack.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/psum_pkg.sv
// Shared constants, lane field geometry and FSM state type for the partial-sum drain path.
package psum_pkg;
  localparam int PE_OUT_W    = 64;
  localparam int LANE_W      = 24;
  localparam int FIFO_DEPTH  = 8;
  localparam int CAPTURE_LAT = 1;
  localparam int LEN_W       = 8;

  localparam int M0_FIELD_W  = 24;
  localparam int M1_FIELD_W  = 16;

  localparam logic [3:0] MASK_M0 = 4'b0011;
  localparam logic [3:0] MASK_M1 = 4'b1111;

  // FIFO entry layout: {last, lane_mask[3:0], lanes[4*LANE_W-1:0]}
  localparam int ENTRY_W = 4 * LANE_W + 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
endpackage

// File: rtl/psum_fifo.sv
// Synchronous result FIFO with occupancy count; storage is not reset, only pointers and count.
module psum_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/psum_drain_unpack.sv
// Drains packed partial sums from the PE array edge, unpacks them into lanes and streams them out.
// Optional PSUM_RELU_EN clamps negative active lanes to zero.
module psum_drain_unpack
  import psum_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mode,
  input  logic                  start,
  input  logic [LEN_W-1:0]      drain_len,
  output logic                  busy,
  output logic                  done,
  output logic                  cell_out_en_pre,
  input  logic [PE_OUT_W-1:0]   cell_word,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [4*LANE_W-1:0]   m_data,
  output logic [3:0]            m_lane_mask,
  output logic                  m_last
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_e                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [LEN_W-1:0]       issued_q, issued_d;
  logic [LEN_W-1:0]       captured_q, captured_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CAPTURE_LAT-1:0] pipe_q, pipe_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   en_q, en_d;

  logic [CW-1:0]          fifo_count;
  logic [ENTRY_W-1:0]     fifo_wdata, fifo_rdata;
  logic                   push, pop, credit;

  function automatic logic signed [LANE_W-1:0] relu(input logic signed [LANE_W-1:0] x);
`ifdef PSUM_RELU_EN
    relu = x[LANE_W-1] ? '0 : x;
`else
    relu = x;
`endif
  endfunction

  // Sign-carry correction already happened in the PE, so mode 0 lanes are taken verbatim.
  function automatic logic [4*LANE_W-1:0] unpack(input logic m, input logic [PE_OUT_W-1:0] w);
    logic signed [LANE_W-1:0] lane [4];
    logic [M1_FIELD_W-1:0]    f;
    for (int i = 0; i < 4; i++) lane[i] = '0;
    if (!m) begin
      lane[0] = relu(w[M0_FIELD_W-1:0]);
      lane[1] = relu(w[2*M0_FIELD_W-1:M0_FIELD_W]);
    end else begin
      for (int i = 0; i < 4; i++) begin
        f       = w[M1_FIELD_W*i +: M1_FIELD_W];
        lane[i] = relu({{(LANE_W-M1_FIELD_W){f[M1_FIELD_W-1]}}, f});
      end
    end
    unpack = {lane[3], lane[2], lane[1], lane[0]};
  endfunction

  // Strobes already issued count against buffer space until their word lands in the FIFO.
  assign credit = (fifo_count + inflight_q) < CW'(FIFO_DEPTH);
  assign push   = pipe_q[CAPTURE_LAT-1];
  assign pop    = m_valid && m_ready;

  assign fifo_wdata = {(captured_q == len_q - LEN_W'(1)),
                       (mode_q ? MASK_M1 : MASK_M0),
                       unpack(mode_q, cell_word)};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    issued_d   = issued_q;
    captured_d = captured_q;
    done_d     = 1'b0;
    en_d       = 1'b0;
    pipe_d[0]  = en_q;
    for (int i = 1; i < CAPTURE_LAT; i++) pipe_d[i] = pipe_q[i-1];

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (drain_len != '0) begin
            mode_d     = mode;
            len_d      = drain_len;
            issued_d   = '0;
            captured_d = '0;
            state_d    = ST_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (issued_q != len_q && credit) begin
          en_d     = 1'b1;
          issued_d = issued_q + LEN_W'(1);
        end
        if (issued_d == len_q) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Finish on the cycle the final beat is accepted so done lands right after it.
        if (inflight_q == '0 &&
            (fifo_count == '0 || (fifo_count == CW'(1) && pop))) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) captured_d = captured_q + LEN_W'(1);
    inflight_d = inflight_q + CW'(en_d) - CW'(push);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      len_q      <= '0;
      issued_q   <= '0;
      captured_q <= '0;
      inflight_q <= '0;
      pipe_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      captured_q <= captured_d;
      inflight_q <= inflight_d;
      pipe_q     <= pipe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      en_q       <= en_d;
    end
  end

  psum_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (fifo_wdata),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count)
  );

  // Gate the unreset storage so idle outputs read as zero.
  assign m_valid         = (fifo_count != '0);
  assign m_data          = m_valid ? fifo_rdata[4*LANE_W-1:0]      : '0;
  assign m_lane_mask     = m_valid ? fifo_rdata[4*LANE_W+3:4*LANE_W] : 4'b0000;
  assign m_last          = m_valid ? fifo_rdata[ENTRY_W-1]          : 1'b0;
  assign busy            = busy_q;
  assign done            = done_q;
  assign cell_out_en_pre = en_q;
endmodule
